load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator-side master for the 16-bit data memory: accepts load/store requests from the core's MEM stage and drives MemRead/MemWrite/Address/WriteData.
- Returns load data or store completion over a valid/ready response channel.
- Byte addresses from the core are translated to the memory's word-indexed interface.
- Byte stores are performed as read-modify-write sequences.

Parameters:
- MEM_WORDS, 256, number of 16-bit words in data memory; word index >= MEM_WORDS is an access fault.

Ports:
- clk  input  1  system clock, all state on posedge
- rst  input  1  asynchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept request (high only in IDLE)
- req_write  input  1  1=store, 0=load
- req_byte  input  1  1=byte access, 0=word access
- req_signed  input  1  byte load: 1=sign-extend, 0=zero-extend
- req_addr  input  16  byte address
- req_wdata  input  16  store data (byte store uses [7:0])
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_rdata  output  16  load result (0 for stores/faults)
- rsp_error  output  1  misaligned or out-of-range access
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe (memory commits on negedge of that cycle)
- MemtoReg  output  1  tied to latched ~req_write during RD
- Address  output  16  word index = req_addr[15:1]
- WriteData  output  16  word to write
- outData  input  16  combinational read data from memory, valid in the same cycle as MemRead

Behaviour:
- Reset (async): state=IDLE; MemRead, MemWrite, MemtoReg, rsp_valid, rsp_error = 0; Address, WriteData, rsp_rdata = 0; req_ready=1 after reset.
- Accept on posedge with req_valid&req_ready; latch write, byte, signed, addr, wdata. Inputs are ignored outside IDLE.
- Endianness: byte at even address = word[15:8]; odd address = word[7:0].
- Fault check at accept:
  - word access with addr[0]=1 -> error;
  - addr[15:1] >= MEM_WORDS -> error.
  - A faulting request goes directly to RESP with rsp_error=1 and rsp_rdata=0; MemRead/MemWrite are never asserted for it.
- States IDLE, RD, WR, RESP:
  - word load: IDLE->RD->RESP. In RD, MemRead=1; outData is captured into rsp_rdata at the closing posedge.
  - byte load: IDLE->RD->RESP. The selected byte is extended per req_signed.
  - word store: IDLE->WR->RESP. In WR, MemWrite=1 and WriteData=wdata.
  - byte store: IDLE->RD->WR->RESP. RD captures the old word; WR writes the merged word, replacing only the addressed byte with wdata[7:0].
  - RESP: rsp_valid=1, held stable until rsp_ready; on rsp_valid&rsp_ready go to IDLE. rsp_ready already high is accepted in the first RESP cycle.
- Latency, accept to rsp_valid: word load 2 cycles; word store 2; byte store 3; fault 1.
- Back-to-back: req_ready is asserted the cycle after the response handshake.
- MemRead and MemWrite are never high simultaneously. Each is high for exactly one cycle per access. Both are registered outputs (glitch-free).
- Address and WriteData hold their values through the strobe cycle. They are don't-care otherwise but must not toggle while a strobe is high.
- Reset mid-operation: strobes drop immediately, the pending request is discarded, and no response is issued. A byte store reset between RD and WR leaves memory unmodified.

Optional Feature:
- BYTE_ACCESS_EN
- Defined: byte loads/stores as above.
- Undefined: RD-before-WR path and byte merge logic are removed. Any request with req_byte=1 faults (1-cycle RESP, rsp_error=1, no memory strobe).

Decomposition:
- Shared package lsu_pkg: state encoding constants (ST_IDLE, ST_RD, ST_WR, ST_RESP), WORD_W=16, byte-lane select constants.
- One natural sub-module: lsu_byte_lane (combinational extract/extend for loads and merge for stores). The FSM and registers stay in load_store_unit.

Test Plan:
- Word load addr=0x0004 with mem word[2]=0xBEEF -> MemRead one cycle with Address=2; rsp_rdata=0xBEEF, rsp_error=0, 2 cycles after accept.
- Byte store addr=0x0005, wdata=0x0012 over word[2]=0xBEEF -> RD then WR with WriteData=0xBE12; subsequent word load of 0x0004 returns 0xBE12.
- Signed byte load addr=0x0004 (byte 0xBE) -> rsp_rdata=0xFFBE; same with req_signed=0 -> 0x00BE.
- Word load addr=0x0003 and addr=0x0200 (MEM_WORDS=256) -> rsp_error=1, rsp_rdata=0, MemRead never asserted.
- Response backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata stable; req_ready=0 throughout; IDLE the cycle after handshake.
- Assert rst during WR of a byte store -> MemWrite falls asynchronously, rsp_valid=0, req_ready=1; target word unchanged or fully written, never partial.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : lsu_pkg                                                     |
// | Purpose    : Shared types and constants for the load/store unit: FSM     |
// |              state encoding, data widths, byte-lane select values and a  |
// |              byte extension helper.                                      |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package lsu_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Big-endian byte placement: the even byte address lives in word[15:8].
  localparam logic LANE_HI = 1'b0;
  localparam logic LANE_LO = 1'b1;

  function automatic logic [WORD_W-1:0] extend_byte(input logic [BYTE_W-1:0] b,
                                                    input logic             sgn);
    return sgn ? {{(WORD_W-BYTE_W){b[BYTE_W-1]}}, b} : {{(WORD_W-BYTE_W){1'b0}}, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface  : load_store_unit_if                                          |
// | Purpose    : Bundles the core-side request/response handshake and the    |
// |              data-memory bus of the load/store unit.                     |
// | Modports   : master - the load/store unit itself (accepts requests,      |
// |                       drives responses and memory strobes)               |
// |              slave  - the environment (core MEM stage + data memory)     |
// | Signals    : req_valid/req_ready/req_write/req_byte/req_signed/req_addr/ |
// |              req_wdata, rsp_valid/rsp_ready/rsp_rdata/rsp_error,         |
// |              MemRead/MemWrite/MemtoReg/Address/WriteData/outData         |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
interface load_store_unit_if;

  logic                       req_valid;
  logic                       req_ready;
  logic                       req_write;
  logic                       req_byte;
  logic                       req_signed;
  logic [lsu_pkg::WORD_W-1:0] req_addr;
  logic [lsu_pkg::WORD_W-1:0] req_wdata;

  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [lsu_pkg::WORD_W-1:0] rsp_rdata;
  logic                       rsp_error;

  logic                       MemRead;
  logic                       MemWrite;
  logic                       MemtoReg;
  logic [lsu_pkg::WORD_W-1:0] Address;
  logic [lsu_pkg::WORD_W-1:0] WriteData;
  logic [lsu_pkg::WORD_W-1:0] outData;

  modport master (
    input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_error,
    input  rsp_ready,
    output MemRead, MemWrite, MemtoReg, Address, WriteData,
    input  outData
  );

  modport slave (
    output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_error,
    output rsp_ready,
    input  MemRead, MemWrite, MemtoReg, Address, WriteData,
    output outData
  );

endinterface
`default_nettype wire

// File: rtl/lsu_byte_lane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : lsu_byte_lane                                               |
// | Purpose    : Combinational byte-lane datapath. Extracts and extends the  |
// |              addressed byte of a memory word for byte loads, and merges  |
// |              a store byte into the old word for read-modify-write.       |
// | Ports      : i_word   - word read from memory                            |
// |              i_lane   - byte address bit 0 (LANE_HI / LANE_LO)           |
// |              i_signed - 1 = sign-extend loaded byte                      |
// |              i_wbyte  - byte to store                                    |
// |              o_load   - extended load byte                               |
// |              o_merged - i_word with the addressed byte replaced          |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  wire logic [WORD_W-1:0] i_word,
  input  wire logic              i_lane,
  input  wire logic              i_signed,
  input  wire logic [BYTE_W-1:0] i_wbyte,
  output logic      [WORD_W-1:0] o_load,
  output logic      [WORD_W-1:0] o_merged
);

  logic [BYTE_W-1:0] w_sel;

  always_comb begin
    w_sel    = (i_lane == LANE_HI) ? i_word[WORD_W-1:BYTE_W] : i_word[BYTE_W-1:0];
    o_load   = extend_byte(w_sel, i_signed);
    o_merged = (i_lane == LANE_HI) ? {i_wbyte, i_word[BYTE_W-1:0]}
                                   : {i_word[WORD_W-1:BYTE_W], i_wbyte};
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : load_store_unit                                             |
// | Purpose    : Initiator-side master for the 16-bit word-indexed data      |
// |              memory. Accepts load/store requests from the MEM stage,     |
// |              translates byte addresses to word indices, performs byte    |
// |              stores as read-modify-write and returns results over a      |
// |              valid/ready response channel.                               |
// | Ports      : clk  - clock, all state on posedge                          |
// |              rst  - asynchronous active-high reset                       |
// |              bus  - load_store_unit_if.master (request, response and     |
// |                     memory bus signals)                                  |
// | Parameters : MEM_WORDS - words in data memory; index >= MEM_WORDS faults  |
// | Config     : BYTE_ACCESS_EN - when defined, byte loads/stores are        |
// |              supported; otherwise every byte request faults.             |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input wire clk,
  input wire rst,
  load_store_unit_if.master bus
);

  localparam logic [16:0] c_mem_words = 17'(MEM_WORDS);

  lsu_state_e        r_state;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_memtoreg;
  logic [WORD_W-1:0] r_address;
  logic [WORD_W-1:0] r_wdata_out;
  logic              r_rsp_valid;
  logic              r_rsp_error;
  logic [WORD_W-1:0] r_rsp_rdata;

  logic [16:0]       w_word_idx;
  logic              w_fault;
  logic              w_rmw;

`ifdef BYTE_ACCESS_EN
  logic              r_write;
  logic              r_byte;
  logic              r_signed;
  logic              r_lane;
  logic [BYTE_W-1:0] r_wbyte;
  logic [WORD_W-1:0] w_lane_load;
  logic [WORD_W-1:0] w_lane_merged;

  lsu_byte_lane u_byte_lane (
    .i_word   (bus.outData),
    .i_lane   (r_lane),
    .i_signed (r_signed),
    .i_wbyte  (r_wbyte),
    .o_load   (w_lane_load),
    .o_merged (w_lane_merged)
  );
`else
  logic w_unused_signed;
  assign w_unused_signed = bus.req_signed;
`endif

  // Fault and read-modify-write decode on the incoming request.
  always_comb begin
    w_word_idx = {2'b00, bus.req_addr[WORD_W-1:1]};
    w_fault    = (!bus.req_byte && bus.req_addr[0]) || (w_word_idx >= c_mem_words);
`ifdef BYTE_ACCESS_EN
    w_rmw      = bus.req_byte;
`else
    w_fault    = w_fault || bus.req_byte;
    w_rmw      = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_memtoreg  <= 1'b0;
      r_address   <= '0;
      r_wdata_out <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_rdata <= '0;
`ifdef BYTE_ACCESS_EN
      r_write     <= 1'b0;
      r_byte      <= 1'b0;
      r_signed    <= 1'b0;
      r_lane      <= 1'b0;
      r_wbyte     <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_address <= {1'b0, bus.req_addr[WORD_W-1:1]};
`ifdef BYTE_ACCESS_EN
            r_write   <= bus.req_write;
            r_byte    <= bus.req_byte;
            r_signed  <= bus.req_signed;
            r_lane    <= bus.req_addr[0];
            r_wbyte   <= bus.req_wdata[BYTE_W-1:0];
`endif
            if (w_fault) begin
              // Faults never touch memory; respond immediately.
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_error <= 1'b1;
              r_rsp_rdata <= '0;
            end else if (bus.req_write && !w_rmw) begin
              r_state     <= ST_WR;
              r_mem_write <= 1'b1;
              r_wdata_out <= bus.req_wdata;
            end else begin
              // Loads and the read half of a byte store.
              r_state     <= ST_RD;
              r_mem_read  <= 1'b1;
              r_memtoreg  <= ~bus.req_write;
            end
          end
        end

        ST_RD: begin
          r_mem_read <= 1'b0;
          r_memtoreg <= 1'b0;
`ifdef BYTE_ACCESS_EN
          if (r_write) begin
            // Old word is on outData now; write back the merged word.
            r_state     <= ST_WR;
            r_mem_write <= 1'b1;
            r_wdata_out <= w_lane_merged;
          end else begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= r_byte ? w_lane_load : bus.outData;
          end
`else
          r_state     <= ST_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_error <= 1'b0;
          r_rsp_rdata <= bus.outData;
`endif
        end

        ST_WR: begin
          r_mem_write <= 1'b0;
          r_state     <= ST_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_error <= 1'b0;
          r_rsp_rdata <= '0;
        end

        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_error = r_rsp_error;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.MemRead   = r_mem_read;
  assign bus.MemWrite  = r_mem_write;
  assign bus.MemtoReg  = r_memtoreg;
  assign bus.Address   = r_address;
  assign bus.WriteData = r_wdata_out;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_load_store_unit                                          |
// | Purpose    : Self-checking bench for load_store_unit with a word-array   |
// |              data memory, a behavioural reference model of the memory    |
// |              contents and request results, directed and random requests. |
// | Config     : follows BYTE_ACCESS_EN the same way as the design.          |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if ifc();

  load_store_unit #(.MEM_WORDS(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  logic [15:0] mem     [256];
  logic [15:0] ref_mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  int          rd_cnt, wr_cnt, both_cnt, addr_bad, m2r_bad, wd_bad;
  logic [15:0] exp_idx;
  logic [15:0] exp_wdata;
  logic        exp_m2r;

  assign ifc.outData = (ifc.Address < 16'd256) ? mem[ifc.Address[7:0]] : 16'h0000;

  // Memory model plus strobe observation; one negedge per strobe cycle.
  always @(negedge clk) begin
    if (ifc.MemRead && ifc.MemWrite) both_cnt++;
    if (ifc.MemRead) begin
      rd_cnt++;
      if (ifc.Address !== exp_idx) addr_bad++;
      if (ifc.MemtoReg !== exp_m2r) m2r_bad++;
    end
    if (ifc.MemWrite) begin
      wr_cnt++;
      if (ifc.Address !== exp_idx) addr_bad++;
      if (ifc.WriteData !== exp_wdata) wd_bad++;
      if (ifc.Address < 16'd256) mem[ifc.Address[7:0]] = ifc.WriteData;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_req(input string tag, input logic wr, input logic byt, input logic sgn,
                        input logic [15:0] addr, input logic [15:0] wdata, input int hold,
                        output logic [15:0] rdata_obs);
    int          idx, b, lat, exp_lat, exp_rd, exp_wr;
    logic        fault;
    logic [15:0] w, exp_rdata, lo8;
    lo8 = wdata & 16'h00FF;
    idx = int'(addr) / 2;
    fault = (!byt && addr[0]) || (idx >= 256);
`ifndef BYTE_ACCESS_EN
    fault = fault || byt;
`endif
    exp_rdata = 16'h0000;
    exp_wdata = 16'h0000;
    exp_idx   = 16'(idx);
    exp_m2r   = ~wr;
    if (fault) begin
      exp_lat = 1; exp_rd = 0; exp_wr = 0;
    end else if (!wr) begin
      exp_lat = 2; exp_rd = 1; exp_wr = 0;
      w = ref_mem[idx];
      if (byt) begin
        b = addr[0] ? int'(w) % 256 : int'(w) / 256;
        exp_rdata = (sgn && b >= 128) ? 16'(b + 'hFF00) : 16'(b);
      end else begin
        exp_rdata = w;
      end
    end else if (!byt) begin
      exp_lat = 2; exp_rd = 0; exp_wr = 1;
      exp_wdata = wdata;
      ref_mem[idx] = wdata;
    end else begin
      exp_lat = 3; exp_rd = 1; exp_wr = 1;
      w = ref_mem[idx];
      exp_wdata = addr[0] ? ((w & 16'hFF00) | lo8) : ((w & 16'h00FF) | 16'(lo8 * 256));
      ref_mem[idx] = exp_wdata;
    end

    check({tag, "_req_ready_idle"}, 32'(ifc.req_ready), 32'd1);
    rd_cnt = 0; wr_cnt = 0; both_cnt = 0; addr_bad = 0; m2r_bad = 0; wd_bad = 0;
    ifc.rsp_ready  = (hold == 0);
    ifc.req_write  = wr;
    ifc.req_byte   = byt;
    ifc.req_signed = sgn;
    ifc.req_addr   = addr;
    ifc.req_wdata  = wdata;
    ifc.req_valid  = 1'b1;
    tick();
    ifc.req_valid  = 1'b0;
    lat = 1;
    while (ifc.rsp_valid !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rsp_error"}, 32'(ifc.rsp_error), 32'(fault));
    check({tag, "_rsp_rdata"}, 32'(ifc.rsp_rdata), 32'(exp_rdata));
    check({tag, "_req_ready_busy"}, 32'(ifc.req_ready), 32'd0);
    rdata_obs = ifc.rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(ifc.rsp_valid), 32'd1);
      check({tag, "_hold_rdata"}, 32'(ifc.rsp_rdata), 32'(exp_rdata));
      check({tag, "_hold_ready"}, 32'(ifc.req_ready), 32'd0);
    end
    ifc.rsp_ready = 1'b1;
    tick();
    ifc.rsp_ready = 1'b0;
    check({tag, "_post_ready"}, 32'(ifc.req_ready), 32'd1);
    check({tag, "_post_valid"}, 32'(ifc.rsp_valid), 32'd0);
    check({tag, "_memread_cnt"}, 32'(rd_cnt), 32'(exp_rd));
    check({tag, "_memwrite_cnt"}, 32'(wr_cnt), 32'(exp_wr));
    check({tag, "_strobe_overlap"}, 32'(both_cnt), 32'd0);
    check({tag, "_strobe_addr"}, 32'(addr_bad), 32'd0);
    check({tag, "_memtoreg"}, 32'(m2r_bad), 32'd0);
    check({tag, "_writedata"}, 32'(wd_bad), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r, old4, a;
    logic        wr, byt, sgn;
    int          waited;
    ifc.req_valid = 1'b0; ifc.req_write = 1'b0; ifc.req_byte = 1'b0;
    ifc.req_signed = 1'b0; ifc.req_addr = '0; ifc.req_wdata = '0;
    ifc.rsp_ready = 1'b0;
    exp_idx = '0; exp_wdata = '0; exp_m2r = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[2] = 16'hBEEF; ref_mem[2] = 16'hBEEF;

    // Reset values while reset is held.
    #1;
    check("rst_req_ready", 32'(ifc.req_ready), 32'd1);
    check("rst_memread", 32'(ifc.MemRead), 32'd0);
    check("rst_memwrite", 32'(ifc.MemWrite), 32'd0);
    check("rst_memtoreg", 32'(ifc.MemtoReg), 32'd0);
    check("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    check("rst_rsp_error", 32'(ifc.rsp_error), 32'd0);
    check("rst_address", 32'(ifc.Address), 32'd0);
    check("rst_writedata", 32'(ifc.WriteData), 32'd0);
    check("rst_rsp_rdata", 32'(ifc.rsp_rdata), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Word load of word[2].
    do_req("wload", 1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000, 0, r);
    check("tp_wload_beef", 32'(r), 32'h0000BEEF);

    // Byte store into the low byte of word[2], then read the word back.
    do_req("bstore", 1'b1, 1'b1, 1'b0, 16'h0005, 16'h0012, 0, r);
    do_req("wload2", 1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000, 1, r);
`ifdef BYTE_ACCESS_EN
    check("tp_bstore_merge", 32'(r), 32'h0000BE12);
`else
    check("tp_bstore_fault", 32'(r), 32'h0000BEEF);
`endif

    // Signed and unsigned byte loads of the high byte 0xBE.
    do_req("bload_s", 1'b0, 1'b1, 1'b1, 16'h0004, 16'h0000, 0, r);
`ifdef BYTE_ACCESS_EN
    check("tp_bload_signed", 32'(r), 32'h0000FFBE);
`else
    check("tp_bload_signed", 32'(r), 32'h00000000);
`endif
    do_req("bload_u", 1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000, 0, r);
`ifdef BYTE_ACCESS_EN
    check("tp_bload_unsigned", 32'(r), 32'h000000BE);
`else
    check("tp_bload_unsigned", 32'(r), 32'h00000000);
`endif

    // Misaligned and out-of-range word loads.
    do_req("misalign", 1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, 0, r);
    do_req("oor", 1'b0, 1'b0, 1'b0, 16'h0200, 16'h0000, 0, r);
    do_req("oor_store", 1'b1, 1'b0, 1'b0, 16'hFFFE, 16'h5A5A, 2, r);
    do_req("top_word", 1'b1, 1'b0, 1'b0, 16'h01FE, 16'hA5C3, 0, r);
    do_req("top_word_ld", 1'b0, 1'b0, 1'b0, 16'h01FE, 16'h0000, 0, r);

    // Backpressure on the response channel.
    do_req("bp_load", 1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000, 5, r);

    // Reset while the write strobe of a store is high, before the memory commit edge.
    old4 = mem[4];
    exp_idx = 16'd4;
`ifdef BYTE_ACCESS_EN
    ifc.req_byte = 1'b1; ifc.req_wdata = 16'h0034;
`else
    ifc.req_byte = 1'b0; ifc.req_wdata = 16'h1234;
`endif
    ifc.req_write = 1'b1; ifc.req_signed = 1'b0; ifc.req_addr = 16'h0008;
    ifc.rsp_ready = 1'b1;
    ifc.req_valid = 1'b1;
    @(posedge clk); #1;
    ifc.req_valid = 1'b0;
    waited = 0;
    while (ifc.MemWrite !== 1'b1 && waited < 6) begin
      @(posedge clk); #1;
      waited++;
    end
    check("rstmid_write_seen", 32'(ifc.MemWrite), 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid_memwrite", 32'(ifc.MemWrite), 32'd0);
    check("rstmid_memread", 32'(ifc.MemRead), 32'd0);
    check("rstmid_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    check("rstmid_req_ready", 32'(ifc.req_ready), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("rstmid_no_rsp", 32'(ifc.rsp_valid), 32'd0);
    check("rstmid_mem_word", 32'(mem[4]), 32'(old4));
    ifc.rsp_ready = 1'b0;

    // Random traffic checked against the reference memory model.
    for (int k = 0; k < 60; k++) begin
      a = 16'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) a = a | 16'h0200;
      wr  = ($urandom_range(0, 1) == 1);
      byt = ($urandom_range(0, 1) == 1);
      sgn = ($urandom_range(0, 1) == 1);
      do_req("rnd", wr, byt, sgn, a, 16'($urandom), int'($urandom_range(0, 3)), r);
    end

    // Final sweep: every word the random phase may have touched matches the model.
    for (int i = 0; i < 40; i++) begin
      check("final_mem", 32'(mem[i]), 32'(ref_mem[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
